regbank_write_arbiter: RTL and testbench
========================================

// Module: regbank_write_arbiter
// PURPOSE
//  Shares the single write port of the register bank between NUM_REQ writeback requesters (e.g. ALU, load unit).
//  Uses a round-robin valid/ready arbiter with a registered write-port stage.
//  Also holds a per-register busy scoreboard: decode reserves destinations, committed writes release them,
//  and decode stalls on busy source operands.
// PARAMETERS
//  REGISTER_SIZE  32  data width of one register / write data
//  ADDRESS_SIZE   5   register address width; 1<<ADDRESS_SIZE registers
//  NUM_REQ        2   number of writeback requesters (>=2)
// PORTS
//  clk           in   1                     clock; all state updates on rising edge
//  reset         in   1                     asynchronous, active-low reset
//  req_valid     in   NUM_REQ               requester k has a write pending
//  req_addr      in   NUM_REQ*ADDRESS_SIZE  dest address, requester k in slice k
//  req_data      in   NUM_REQ*REGISTER_SIZE write data, requester k in slice k
//  req_ready     out  NUM_REQ               one-hot grant; transfer when valid&ready at the edge
//  rsv_valid     in   1                     decode reserves rsv_addr as pending destination
//  rsv_addr      in   ADDRESS_SIZE          register being reserved
//  chk_addr1     in   ADDRESS_SIZE          source operand 1 to check
//  chk_addr2     in   ADDRESS_SIZE          source operand 2 to check
//  chk_busy1     out  1                     busy[chk_addr1], combinational
//  chk_busy2     out  1                     busy[chk_addr2], combinational
//  bank_write    out  1                     to register bank write enable
//  bank_addr     out  ADDRESS_SIZE          to register bank addr_in
//  bank_data     out  REGISTER_SIZE         to register bank data_in
// BEHAVIOUR
//  Reset (reset==0, async): bank_write=0, bank_addr=0, bank_data=0, busy[]=all 0, rr_ptr=0.
//   req_ready is then all 0; it stays 0 until the first edge after release.
//  Arbitration: combinational; search starts at rr_ptr, increments mod NUM_REQ; first k with req_valid[k] wins.
//   Winner gets req_ready[k]=1; all other ready bits are 0. No valid requester -> req_ready=0.
//   req_ready never asserts while reset==0.
//  Accept at edge N (req_valid[k]&req_ready[k]):
//   - bank_write=1, bank_addr=req_addr[k], bank_data=req_data[k] for cycle N..N+1.
//   - rr_ptr <= (k+1) mod NUM_REQ.
//   No accept -> bank_write<=0; addr/data hold their last values; rr_ptr holds.
//   Latency accept->bank write = 1 cycle. Throughput is 1 write per cycle. bank_* change only at rising edges.
//  Requester rule: once valid, a requester holds valid/addr/data stable until accepted.
//   The arbiter does not check this rule.
//  Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//  Scoreboard (1<<ADDRESS_SIZE bits), updated at each edge:
//   - set:   rsv_valid -> busy[rsv_addr] <= 1.
//   - clear: accepted write (same edge as accept) -> busy[req_addr[k]] <= 0.
//   - set and clear of the same address in one edge: set wins (a new producer is outstanding).
//   - Different addresses: both apply.
//   - Reserving an already-busy register is legal; the bit stays 1 and the first write clears it (no count).
//   - Clearing a non-busy register is legal; no effect.
//  Busy check: chk_busyN = busy[chk_addrN], from the current flop state.
//   No bypass of same-cycle set/clear; a write accepted at edge N clears busy from cycle N+1.
//  Register 0 gets no special treatment: writes and reservations apply like any other address.
//  Reset asserted mid-transfer: any pending bank_write drops at once; the write is lost.
//   Busy bits clear, so decode must be flushed together with reset.
// TESTING
//  1. Reset: reset=0 with random inputs -> bank_write=0, req_ready=0, chk_busy1/2=0 for all addresses.
//  2. Single req: req_valid=01, addr=5, data=0xDEADBEEF -> ready=01 that cycle; next cycle bank_write=1, addr=5, data=0xDEADBEEF.
//  3. Round-robin: both valid for 4 cycles after reset -> grant order 0,1,0,1; bank_addr follows the winners.
//  4. Scoreboard: rsv addr 7; next cycle chk_addr1=7 -> busy1=1. Accept write to 7 -> busy1=0 the following cycle.
//  5. Collision: rsv_valid addr 3 and accepted write to 3 on the same edge -> busy[3]=1 afterwards.
//  6. Async reset while bank_write=1 and busy[9]=1 -> bank_write=0, busy[9]=0 with no clock edge.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port, plus a per-register busy scoreboard.
// Latency: accept -> bank write 1 cycle; backpressure: one-hot req_ready, losing requesters hold until granted.
module regbank_write_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int NUM_REQ       = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*REGISTER_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              rsv_valid,
  input  logic [ADDRESS_SIZE-1:0]           rsv_addr,
  input  logic [ADDRESS_SIZE-1:0]           chk_addr1,
  input  logic [ADDRESS_SIZE-1:0]           chk_addr2,
  output logic                              chk_busy1,
  output logic                              chk_busy2,
  output logic                              bank_write,
  output logic [ADDRESS_SIZE-1:0]           bank_addr,
  output logic [REGISTER_SIZE-1:0]          bank_data
);

  localparam int NUM_REG = 1 << ADDRESS_SIZE;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_nxt;
  logic                     arb_en;
  logic                     win_vld;
  logic [NUM_REQ-1:0]       grant;
  logic [ADDRESS_SIZE-1:0]  sel_addr;
  logic [REGISTER_SIZE-1:0] sel_data;
  logic                     accept;
  logic [NUM_REG-1:0]       busy;
  logic [NUM_REG-1:0]       busy_nxt;

  // Search from rr_ptr upward (wrapping); the first valid requester wins.
  always_comb begin
    int idx;
    int nxt;
    idx      = 0;
    nxt      = 0;
    win_vld  = 1'b0;
    grant    = '0;
    sel_addr = '0;
    sel_data = '0;
    rr_nxt   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req_valid[idx]) begin
        win_vld     = 1'b1;
        grant[idx]  = 1'b1;
        sel_addr    = req_addr[idx*ADDRESS_SIZE +: ADDRESS_SIZE];
        sel_data    = req_data[idx*REGISTER_SIZE +: REGISTER_SIZE];
        nxt         = idx + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        rr_nxt      = PTR_W'(nxt);
      end
    end
  end

  // Grants are held off until the first edge after reset release.
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en & win_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_en <= 1'b0;
      rr_ptr <= '0;
    end else begin
      arb_en <= 1'b1;
      if (accept) rr_ptr <= rr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_write <= 1'b0;
      bank_addr  <= '0;
      bank_data  <= '0;
    end else begin
      bank_write <= accept;
      if (accept) begin
        bank_addr <= sel_addr;
        bank_data <= sel_data;
      end
    end
  end

  // Clear before set so a same-edge reservation of the written address stays busy.
  always_comb begin
    busy_nxt = busy;
    if (accept)    busy_nxt[sel_addr] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign chk_busy1 = busy[chk_addr1];
  assign chk_busy2 = busy[chk_addr2];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench: stimulus pushes expected bank writes into a queue, a negedge monitor pops and compares.
module tb_regbank_write_arbiter;

  localparam int RS = 32;
  localparam int AS = 5;
  localparam int NR = 2;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*AS-1:0] req_addr;
  logic [NR*RS-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rsv_valid;
  logic [AS-1:0]   rsv_addr;
  logic [AS-1:0]   chk_addr1;
  logic [AS-1:0]   chk_addr2;
  logic            chk_busy1;
  logic            chk_busy2;
  logic            bank_write;
  logic [AS-1:0]   bank_addr;
  logic [RS-1:0]   bank_data;

  typedef struct packed {
    logic [AS-1:0] a;
    logic [RS-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  regbank_write_arbiter #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .bank_write(bank_write), .bank_addr(bank_addr), .bank_data(bank_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset && bank_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", bank_addr, bank_data);
      end else begin
        e = exp_q.pop_front();
        check("bank_addr", 64'(bank_addr), 64'(e.a));
        check("bank_data", 64'(bank_data), 64'(e.d));
      end
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NR-1:0] v, input logic [AS-1:0] a0, input logic [RS-1:0] d0,
                         input logic [AS-1:0] a1, input logic [RS-1:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  logic [RS-1:0] rr_data [NR];

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;

    // Reset with random inputs: nothing may escape, all busy bits read 0.
    for (int i = 0; i < 32; i++) begin
      req_valid = NR'($urandom);
      req_addr  = (NR*AS)'($urandom);
      req_data  = {$urandom, $urandom};
      rsv_valid = 1'($urandom);
      rsv_addr  = AS'($urandom);
      chk_addr1 = AS'(i);
      chk_addr2 = AS'(31 - i);
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_busy", 64'({chk_busy1, chk_busy2}), 64'd0);
      if (i % 8 == 0) check("rst_bank_write", 64'(bank_write), 64'd0);
    end
    rsv_valid = 1'b0;

    // Single request; ready held off until first edge after release.
    edge_step();
    reset = 1'b1;
    set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1 check("ready_before_first_edge", 64'(req_ready), 64'd0);
    edge_step();
    check("single_ready", 64'(req_ready), 64'b01);
    exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    edge_step();
    req_valid = '0;
    check("single_bank_write", 64'(bank_write), 64'd1);

    // Round-robin from a fresh reset: grants 0,1,0,1.
    edge_step();
    reset = 1'b0;
    #1 reset = 1'b1;
    rr_data[0] = 32'hA000_0000;
    rr_data[1] = 32'hB000_0000;
    set_req(2'b11, 5'd10, rr_data[0], 5'd11, rr_data[1]);
    edge_step();
    for (int c = 0; c < 4; c++) begin
      set_req(2'b11, 5'd10, rr_data[0], 5'd11, rr_data[1]);
      #1 check("rr_ready", 64'(req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
      exp_q.push_back('{a: (c % 2 == 0) ? 5'd10 : 5'd11, d: rr_data[c % 2]});
      edge_step();
      rr_data[c % 2] = rr_data[c % 2] + 1;
    end
    req_valid = '0;

    // Reserve 7, then a write to 7 releases it one cycle after the accept.
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd8;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    #1 check("busy7_before_set", 64'(chk_busy1), 64'd0);
    edge_step();
    rsv_valid = 1'b0;
    check("busy7_set", 64'(chk_busy1), 64'd1);
    check("busy8_clear", 64'(chk_busy2), 64'd0);
    set_req(2'b01, 5'd7, 32'h0000_0077, 5'd0, 32'h0);
    #1 check("w7_ready", 64'(req_ready), 64'b01);
    check("busy7_no_bypass", 64'(chk_busy1), 64'd1);
    exp_q.push_back('{a: 5'd7, d: 32'h0000_0077});
    edge_step();
    req_valid = '0;
    check("busy7_released", 64'(chk_busy1), 64'd0);

    // Collision on 3: same-edge reserve and write leaves it busy.
    chk_addr1 = 5'd3;
    chk_addr2 = 5'd4;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd3;
    edge_step();
    check("busy3_set", 64'(chk_busy1), 64'd1);
    set_req(2'b10, 5'd0, 32'h0, 5'd3, 32'h3333_0001);
    #1 check("w3_ready", 64'(req_ready), 64'b10);
    exp_q.push_back('{a: 5'd3, d: 32'h3333_0001});
    edge_step();
    rsv_valid = 1'b0;
    check("busy3_collision", 64'(chk_busy1), 64'd1);

    // Different addresses on one edge: clear 3, set 4.
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    set_req(2'b10, 5'd0, 32'h0, 5'd3, 32'h3333_0002);
    #1 check("w3b_ready", 64'(req_ready), 64'b10);
    exp_q.push_back('{a: 5'd3, d: 32'h3333_0002});
    edge_step();
    rsv_valid = 1'b0;
    req_valid = '0;
    check("busy3_cleared", 64'(chk_busy1), 64'd0);
    check("busy4_set", 64'(chk_busy2), 64'd1);

    // Async reset while a write is on the bank port and busy[9] is set.
    chk_addr1 = 5'd9;
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    edge_step();
    rsv_valid = 1'b0;
    check("busy9_set", 64'(chk_busy1), 64'd1);
    set_req(2'b01, 5'd20, 32'h2020_2020, 5'd0, 32'h0);
    #1 check("w20_ready", 64'(req_ready), 64'b01);
    edge_step();
    req_valid = '0;
    check("pre_reset_bank_write", 64'(bank_write), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("async_bank_write", 64'(bank_write), 64'd0);
    check("async_bank_addr", 64'(bank_addr), 64'd0);
    check("async_busy9", 64'(chk_busy1), 64'd0);
    check("async_ready", 64'(req_ready), 64'd0);
    edge_step();
    reset = 1'b1;
    edge_step();
    edge_step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
